freq_gate_counter: RTL and testbench

Gated-window frequency counter that sits at the front of the frequency-display pipeline. It synchronises the raw external `signal` and counts its rising edges over a fixed gate of `GATE_CYCLES` clocks. At the end of each gate it latches the edge count as a binary frequency result. That result feeds the binary-to-BCD stage and then the 7-segment digit multiplexer.

---
 rtl/freq_pkg.sv | 17 +
 rtl/freq_gate_counter_if.sv | 26 ++
 rtl/sig_sync_edge.sv | 29 ++
 rtl/freq_gate_counter.sv | 121 ++++++++++++
 tb/tb_freq_gate_counter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-display pipeline front end:
// FSM state encoding, arming length and the 4-digit display clamp.
package freq_pkg;

  // Gate-counter FSM: ARM settles the synchroniser, COUNT runs gates.
  typedef enum logic {
    ARM   = 1'b0,
    COUNT = 1'b1
  } state_e;

  // Number of cycles spent in ARM after reset release.
  localparam int unsigned ARM_CYCLES = 3;

  // Largest value the 4-digit 7-segment display can show.
  localparam int unsigned FREQ_DISP_MAX = 9999;

endpackage

// File: rtl/freq_gate_counter_if.sv
// Measurement bus of the gated frequency counter: the raw waveform going
// in and the latched result going out. The counter uses the slave side.
interface freq_gate_counter_if #(
  parameter int unsigned CNT_W = 32
);

  logic             signal;
  logic [CNT_W-1:0] freq;
  logic             freq_valid;
  logic             overflow;

  modport master (
    output signal,
    input  freq,
    input  freq_valid,
    input  overflow
  );

  modport slave (
    input  signal,
    output freq,
    output freq_valid,
    output overflow
  );

endinterface

// File: rtl/sig_sync_edge.sv
// Two-flop synchroniser for an asynchronous input followed by a
// rising-edge detector. Reused for any async input in the design.
module sig_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchroniser chain plus one delayed copy used for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/freq_gate_counter.sv
// Gated-window frequency counter. Counts synchronised rising edges of
// bus.signal over GATE_CYCLES clocks and latches the count at the end of
// every gate, back to back with no dead cycles.
// Optional feature: define FREQ_CLAMP_EN to clamp results to 9999 for the
// 4-digit display; otherwise the clamp is the full counter range.
module freq_gate_counter
  import freq_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  freq_gate_counter_if.slave  bus
);

  localparam int unsigned    TW         = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [1:0]     ARM_LAST   = 2'(ARM_CYCLES - 1);
`ifdef FREQ_CLAMP_EN
  localparam logic [CNT_W-1:0] CLAMP = CNT_W'(FREQ_DISP_MAX);
`else
  localparam logic [CNT_W-1:0] CLAMP = '1;
`endif

  state_e           state_q, state_d;
  logic [1:0]       arm_cnt_q, arm_cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             clip_q, clip_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic sig_edge;
  logic at_clamp;

  sig_sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (bus.signal),
    .edge_o  (sig_edge)
  );

  // The counter stops at the clamp; clip_q remembers that edges were lost.
  assign at_clamp = (edge_cnt_q == CLAMP);

  // State and datapath registers; reset discards any partial gate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARM;
      arm_cnt_q  <= '0;
      timer_q    <= '0;
      edge_cnt_q <= '0;
      clip_q     <= 1'b0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      timer_q    <= timer_d;
      edge_cnt_q <= edge_cnt_d;
      clip_q     <= clip_d;
      freq_q     <= freq_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  // Next state: ARM waits out the synchroniser, COUNT runs gates and
  // folds an edge seen on the terminal cycle into the ending window.
  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    timer_d    = timer_q;
    edge_cnt_d = edge_cnt_q;
    clip_d     = clip_q;
    freq_d     = freq_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    case (state_q)
      ARM: begin
        timer_d    = '0;
        edge_cnt_d = '0;
        clip_d     = 1'b0;
        if (arm_cnt_q == ARM_LAST) begin
          state_d   = COUNT;
          arm_cnt_d = '0;
        end else begin
          arm_cnt_d = arm_cnt_q + 2'd1;
        end
      end
      COUNT: begin
        if (timer_q == TIMER_LAST) begin
          timer_d    = '0;
          edge_cnt_d = '0;
          clip_d     = 1'b0;
          freq_d     = (sig_edge && !at_clamp) ? edge_cnt_q + 1'b1 : edge_cnt_q;
          ovf_d      = clip_q | (sig_edge & at_clamp);
          valid_d    = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
          if (sig_edge) begin
            if (at_clamp) begin
              clip_d = 1'b1;
            end else begin
              edge_cnt_d = edge_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ARM;
    endcase
  end

  assign bus.freq       = freq_q;
  assign bus.freq_valid = valid_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed self-checking bench for freq_gate_counter. One instance runs a
// 100-cycle gate for the functional scenarios, a second one a 40000-cycle
// gate for the clamp scenario (expectation depends on FREQ_CLAMP_EN).
module tb_freq_gate_counter;

  logic clk = 1'b0;
  logic rst_n;
  logic rstC_n;

  int vectors     = 0;
  int miscompares = 0;
  int mode        = 0;
  int modeC       = 0;
  int phase       = 0;

  freq_gate_counter_if #(.CNT_W(32)) bus ();
  freq_gate_counter_if #(.CNT_W(32)) busC ();

  freq_gate_counter #(.GATE_CYCLES(100), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  freq_gate_counter #(.GATE_CYCLES(40000), .CNT_W(32)) dutC (
    .clk   (clk),
    .rst_n (rstC_n),
    .bus   (busC)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Advance one cycle, sample point #1 after the edge; also drives the
  // waveform generators (mode 1 = period-10 tone, modeC 2 = period 2).
  task automatic tick();
    @(posedge clk);
    #1;
    phase++;
    if (mode == 1) bus.signal = ((phase % 10) < 5);
    if (modeC == 2) busC.signal = ~busC.signal;
  endtask

  task automatic test_reset();
    mode = 1;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors += 3;
      if (bus.freq !== 32'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_freq: got %0d expected 0", bus.freq);
      end
      if (bus.overflow !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_overflow: got %b expected 0", bus.overflow);
      end
      if (bus.freq_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_valid: got %b expected 0", bus.freq_valid);
      end
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 102; i++) begin
      tick();
      vectors++;
      if (bus.freq_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL early_valid cycle %0d: got %b expected 0", i, bus.freq_valid);
      end
    end
    tick();
    vectors += 3;
    if (bus.freq_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL first_valid_103: got %b expected 1", bus.freq_valid);
    end
    if (bus.freq !== 32'd10) begin
      miscompares++;
      $display("[TB] FAIL first_freq: got %0d expected 10", bus.freq);
    end
    if (bus.overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL first_overflow: got %b expected 0", bus.overflow);
    end
  endtask

  task automatic test_steady_tone();
    for (int r = 0; r < 5; r++) begin
      repeat (99) tick();
      vectors += 2;
      if (bus.freq_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL tone_gap_valid %0d: got %b expected 0", r, bus.freq_valid);
      end
      if (bus.freq !== 32'd10) begin
        miscompares++;
        $display("[TB] FAIL tone_hold_freq %0d: got %0d expected 10", r, bus.freq);
      end
      tick();
      vectors += 3;
      if (bus.freq_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL tone_valid %0d: got %b expected 1", r, bus.freq_valid);
      end
      if (bus.freq !== 32'd10) begin
        miscompares++;
        $display("[TB] FAIL tone_freq %0d: got %0d expected 10", r, bus.freq);
      end
      if (bus.overflow !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL tone_overflow %0d: got %b expected 0", r, bus.overflow);
      end
    end
  endtask

  task automatic test_static_high();
    mode = 0;
    bus.signal = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (103) tick();
    vectors += 3;
    if (bus.freq_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL static_valid: got %b expected 1", bus.freq_valid);
    end
    if (bus.freq !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL static_freq: got %0d expected 0", bus.freq);
    end
    if (bus.overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL static_overflow: got %b expected 0", bus.overflow);
    end
  endtask

  task automatic test_terminal_edge();
    mode = 0;
    bus.signal = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (100) tick();
    bus.signal = 1'b1;
    repeat (3) tick();
    vectors += 2;
    if (bus.freq_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL term_valid: got %b expected 1", bus.freq_valid);
    end
    if (bus.freq !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL term_freq: got %0d expected 1", bus.freq);
    end
    repeat (100) tick();
    vectors += 2;
    if (bus.freq_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL term_next_valid: got %b expected 1", bus.freq_valid);
    end
    if (bus.freq !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL term_next_freq: got %0d expected 0", bus.freq);
    end
  endtask

  task automatic test_reset_mid_gate();
    int n;
    bit found;
    mode = 1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (103) tick();
    vectors++;
    if (bus.freq !== 32'd10) begin
      miscompares++;
      $display("[TB] FAIL mid_pre_freq: got %0d expected 10", bus.freq);
    end
    repeat (50) tick();
    rst_n = 1'b0;
    tick();
    vectors += 2;
    if (bus.freq !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_freq: got %0d expected 0", bus.freq);
    end
    if (bus.freq_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_valid: got %b expected 0", bus.freq_valid);
    end
    rst_n = 1'b1;
    n = 0;
    found = 1'b0;
    while (!found && n < 150) begin
      tick();
      n++;
      if (bus.freq_valid === 1'b1) found = 1'b1;
    end
    vectors += 2;
    if (!found || n != 103) begin
      miscompares++;
      $display("[TB] FAIL mid_latency: got %0d cycles (found=%b) expected 103", n, found);
    end
    if (bus.freq !== 32'd10) begin
      miscompares++;
      $display("[TB] FAIL mid_freq: got %0d expected 10", bus.freq);
    end
  endtask

  task automatic test_clamp();
    logic [31:0] expFreq;
    logic        expOvf;
`ifdef FREQ_CLAMP_EN
    expFreq = 32'd9999;
    expOvf  = 1'b1;
`else
    expFreq = 32'd20000;
    expOvf  = 1'b0;
`endif
    modeC = 2;
    busC.signal = 1'b0;
    rstC_n = 1'b0;
    tick();
    tick();
    rstC_n = 1'b1;
    repeat (40003) tick();
    vectors += 3;
    if (busC.freq_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL clamp_valid: got %b expected 1", busC.freq_valid);
    end
    if (busC.freq !== expFreq) begin
      miscompares++;
      $display("[TB] FAIL clamp_freq: got %0d expected %0d", busC.freq, expFreq);
    end
    if (busC.overflow !== expOvf) begin
      miscompares++;
      $display("[TB] FAIL clamp_overflow: got %b expected %b", busC.overflow, expOvf);
    end
  endtask

  // Scenario sequence.
  initial begin
    rst_n       = 1'b0;
    rstC_n      = 1'b0;
    bus.signal  = 1'b0;
    busC.signal = 1'b0;
    test_reset();
    test_steady_tone();
    test_static_high();
    test_terminal_edge();
    test_reset_mid_gate();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
